hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Multi-cycle multiply/divide scheduler and HI/LO register owner for the execute stage of the MIPS core. Consumes the 6-bit instruction code produced by decode, sequences MULT/MULTU/DIV/DIVU over several cycles while holding EX with a stall request, and serves MTHI/MTLO/MFHI/MFLO. Sits beside the ALU in EX; the pipeline controller ORs `stall_req` into its EX stall.

## Interface
- `MUL_CYCLES`, 2, number of cycles the registered multiplier occupies (≥1)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  an instruction occupies EX
- `ex_inscode`  in  6  decoded code: 11 DIV, 12 DIVU, 13 MULT, 14 MULTU, 41 MFHI, 42 MFLO, 43 MTHI, 44 MTLO; others ignored
- `ex_rs_val`  in  32  rs operand (dividend / multiplicand / MT source)
- `ex_rt_val`  in  32  rt operand (divisor / multiplier)
- `ex_flush`  in  1  EX instruction cancelled (exception/ERET)
- `stall_req`  out  1  hold EX; combinational from state and inputs
- `mfhilo_data`  out  32  HI for code 41, LO for code 42, else 0
- `hi_o`, `lo_o`  out  32  architectural HI/LO

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, `ex_valid`, code 13/14, no flush: latch operands, counter←MUL_CYCLES−1, →MUL; `stall_req`=1 this cycle.
- IDLE, code 11/12: latch |rs|,|rt| (unsigned for 12) and sign flags, counter←31, →DIV; `stall_req`=1.
- MUL: product 64-bit (signed for 13, unsigned for 14); counter decrements; at 0 write HI←prod[63:32], LO←prod[31:0], →DONE.
- DIV: one restoring radix-2 step per cycle in sub-module; at counter 0 write sign-corrected result, →DONE. Quotient negated if signs differ (DIV only); remainder takes sign of dividend.
- Divide by zero is defined: unsigned q=0xFFFF_FFFF, r=|rs|, then sign fixup (DIV rs<0 → LO=1, HI=rs).
- DONE: `stall_req`=0, `ex_valid` ignored (same instruction still in EX), →IDLE.
- MTHI/MTLO in IDLE with `ex_valid`, no flush: write HI/LO at clock edge, no stall.
- MFHI/MFLO: `mfhilo_data` reads current HI/LO combinationally; no stall.
- `ex_flush` in any state: →IDLE next cycle, no HI/LO write, no new op accepted that cycle, `stall_req`=0.
- Reset: state IDLE, HI=LO=0, counter 0, `stall_req`=0, `mfhilo_data`=0.

## Timing
- MULT/MULTU: `stall_req` high 1+MUL_CYCLES cycles; HI/LO valid in DONE cycle.
- DIV/DIVU: `stall_req` high 33 cycles; HI/LO valid in DONE cycle.
- MTHI→MFHI in next EX cycle returns new value (register already written).
- Flush wins over completion in the same cycle: no write.
- Reset mid-operation aborts immediately (asynchronous).

## Configuration
- `DIV_ZERO_FAST_EN` defined: DIV/DIVU with rt==0 writes the defined zero-divide result at the accept edge and goes IDLE→DONE; `stall_req` high 1 cycle.
- Undefined: zero divisor runs all 32 iterations; identical HI/LO values, 33-cycle stall.

## Structure
- Package `hilo_pkg`: inscode constants (11–14, 41–44), state enum, `DIV_ITERS`=32.
- Sub-module `div_iter`: one restoring step (partial remainder, quotient shift); controller owns counter, sign fixup, HI/LO.

## Test plan
- MULT rs=0xFFFF_FFFE, rt=3 → HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; stall exactly 3 cycles (MUL_CYCLES=2).
- DIVU rs=100, rt=7 → LO=14, HI=2; stall 33 cycles, DONE cycle has stall low.
- DIV rs=0xFFFF_FFF9(−7), rt=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIV rs=5, rt=0 → LO=0xFFFF_FFFF, HI=5; 1-cycle stall with `DIV_ZERO_FAST_EN`, 33 without.
- DIVU with `ex_flush` at 10th busy cycle → IDLE next cycle, HI/LO unchanged, stall low.
- MTHI 0x1234_5678 then MFHI next cycle → `mfhilo_data`=0x1234_5678; async `rst` mid-MULT → HI=LO=0, stall low immediately.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: instruction
// codes, controller states, and the divide sign-correction helper.
package hilo_pkg;

  localparam logic [5:0] IC_DIV   = 6'd11;
  localparam logic [5:0] IC_DIVU  = 6'd12;
  localparam logic [5:0] IC_MULT  = 6'd13;
  localparam logic [5:0] IC_MULTU = 6'd14;
  localparam logic [5:0] IC_MFHI  = 6'd41;
  localparam logic [5:0] IC_MFLO  = 6'd42;
  localparam logic [5:0] IC_MTHI  = 6'd43;
  localparam logic [5:0] IC_MTLO  = 6'd44;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Magnitude of v; only treated as two's complement when is_signed is set.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

  // Applies the sign rules to an unsigned quotient/remainder pair.
  function automatic hilo_t div_fixup(input logic [31:0] q_mag,
                                      input logic [31:0] r_mag,
                                      input logic        q_neg,
                                      input logic        r_neg);
    hilo_t res;
    res.lo = q_neg ? -q_mag : q_mag;
    res.hi = r_neg ? -r_mag : r_mag;
    return res;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_iter.sv
// One restoring radix-2 division step: shifts the next dividend bit into the
// partial remainder and shifts the resulting quotient bit into quo.
module div_iter (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  // quo_i holds the unconsumed dividend bits on top and the quotient below,
  // so its MSB is always the next dividend bit.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {1'b0, dvs_i};
    ge      = (shifted >= {1'b0, dvs_i});
    rem_o   = ge ? diff[31:0] : shifted[31:0];
    quo_o   = {quo_i[30:0], ge};
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Execute-stage multiply/divide sequencer and HI/LO owner.
// Optional DIV_ZERO_FAST_EN: divide by zero completes at the accept edge.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_inscode,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] ex_rt_val,
  input  logic        ex_flush,
  output logic        stall_req,
  output logic [31:0] mfhilo_data,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic [31:0]        rem_q, rem_d;
  logic               mul_signed_q, mul_signed_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               stall_c;

  logic               is_mul;
  logic               is_div;
  logic               div_signed;
  logic [31:0]        rs_abs;
  logic [31:0]        rt_abs;
  logic               q_neg_new;
  logic               r_neg_new;
  logic [63:0]        a_ext;
  logic [63:0]        b_ext;
  logic [63:0]        prod;
  logic [31:0]        div_rem;
  logic [31:0]        div_quo;
  hilo_t              div_res;

  assign is_mul     = (ex_inscode == IC_MULT) || (ex_inscode == IC_MULTU);
  assign is_div     = (ex_inscode == IC_DIV)  || (ex_inscode == IC_DIVU);
  assign div_signed = (ex_inscode == IC_DIV);
  assign rs_abs     = abs32(ex_rs_val, div_signed);
  assign rt_abs     = abs32(ex_rt_val, div_signed);
  assign q_neg_new  = div_signed && (ex_rs_val[31] ^ ex_rt_val[31]);
  assign r_neg_new  = div_signed && ex_rs_val[31];

  // Truncated 64x64 product of sign/zero-extended operands equals the
  // signed or unsigned 32x32 product, so one multiplier serves both.
  assign a_ext = {{32{mul_signed_q & op_a_q[31]}}, op_a_q};
  assign b_ext = {{32{mul_signed_q & op_b_q[31]}}, op_b_q};
  assign prod  = a_ext * b_ext;

  div_iter u_div_iter (
    .rem_i (rem_q),
    .quo_i (op_a_q),
    .dvs_i (op_b_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  assign div_res = div_fixup(div_quo, div_rem, q_neg_q, r_neg_q);

`ifdef DIV_ZERO_FAST_EN
  hilo_t zero_res;
  assign zero_res = div_fixup(32'hFFFF_FFFF, rs_abs, q_neg_new, r_neg_new);
`endif

  // NOTE: every signal written here gets a default first so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rem_d        = rem_q;
    mul_signed_d = mul_signed_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    stall_c      = 1'b0;

    if (ex_flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ex_valid) begin
            if (is_mul) begin
              op_a_d       = ex_rs_val;
              op_b_d       = ex_rt_val;
              mul_signed_d = (ex_inscode == IC_MULT);
              cnt_d        = CNT_W'(MUL_CYCLES - 1);
              state_d      = ST_MUL;
              stall_c      = 1'b1;
            end else if (is_div) begin
              op_a_d  = rs_abs;
              op_b_d  = rt_abs;
              rem_d   = '0;
              q_neg_d = q_neg_new;
              r_neg_d = r_neg_new;
              cnt_d   = CNT_W'(DIV_ITERS - 1);
              state_d = ST_DIV;
              stall_c = 1'b1;
`ifdef DIV_ZERO_FAST_EN
              if (ex_rt_val == '0) begin
                hi_d    = zero_res.hi;
                lo_d    = zero_res.lo;
                cnt_d   = '0;
                state_d = ST_DONE;
              end
`endif
            end else if (ex_inscode == IC_MTHI) begin
              hi_d = ex_rs_val;
            end else if (ex_inscode == IC_MTLO) begin
              lo_d = ex_rs_val;
            end
          end
        end
        ST_MUL: begin
          stall_c = 1'b1;
          if (cnt_q == '0) begin
            hi_d    = prod[63:32];
            lo_d    = prod[31:0];
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DIV: begin
          stall_c = 1'b1;
          rem_d   = div_rem;
          op_a_d  = div_quo;
          if (cnt_q == '0) begin
            hi_d    = div_res.hi;
            lo_d    = div_res.lo;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        // The completed instruction is still in EX; let it leave.
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reset is asynchronous, so the stall must drop the moment it asserts.
  assign stall_req = stall_c & ~rst;

  always_comb begin
    unique case (ex_inscode)
      IC_MFHI: mfhilo_data = hi_q;
      IC_MFLO: mfhilo_data = lo_q;
      default: mfhilo_data = '0;
    endcase
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rem_q        <= '0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rem_q        <= rem_d;
      mul_signed_q <= mul_signed_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus randomized
// operations checked against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [5:0]  ex_inscode;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_flush;
  logic        stall_req;
  logic [31:0] mfhilo_data;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  hilo_muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_inscode  (ex_inscode),
    .ex_rs_val   (ex_rs_val),
    .ex_rt_val   (ex_rt_val),
    .ex_flush    (ex_flush),
    .stall_req   (stall_req),
    .mfhilo_data (mfhilo_data),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural result {HI, LO} after executing one instruction.
  function automatic logic [63:0] ref_hilo(input logic [5:0] code, input logic [31:0] rs,
                                           input logic [31:0] rt, input logic [31:0] cur_hi,
                                           input logic [31:0] cur_lo);
    longint a, b, p, q, r;
    logic [63:0] u;
    case (code)
      IC_MULT: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        p = a * b;
        return 64'(p);
      end
      IC_MULTU: begin
        u = {32'b0, rs} * {32'b0, rt};
        return u;
      end
      IC_DIVU: begin
        if (rt == 0) return {rs, 32'hFFFF_FFFF};
        return {rs % rt, rs / rt};
      end
      IC_DIV: begin
        if (rt == 0) return {rs, (rs[31] ? 32'd1 : 32'hFFFF_FFFF)};
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
      end
      IC_MTHI: return {rs, cur_lo};
      IC_MTLO: return {cur_hi, rs};
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  function automatic int ref_stall(input logic [5:0] code, input logic [31:0] rt);
    if (code == IC_MULT || code == IC_MULTU) return 1 + MUL_CYCLES;
    if (code == IC_DIV || code == IC_DIVU) begin
`ifdef DIV_ZERO_FAST_EN
      if (rt == 0) return 1;
`endif
      return 1 + DIV_ITERS;
    end
    return 0;
  endfunction

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    ex_inscode = 6'd0;
    ex_rs_val  = '0;
    ex_rt_val  = '0;
    ex_flush   = 1'b0;
  endtask

  task automatic check_mf(input string tag);
    ex_valid   = 1'b1;
    ex_inscode = IC_MFHI;
    #1;
    check({tag, " mfhi"}, 64'(mfhilo_data), 64'(m_hi));
    check({tag, " mf stall"}, 64'(stall_req), 64'(0));
    ex_inscode = IC_MFLO;
    #1;
    check({tag, " mflo"}, 64'(mfhilo_data), 64'(m_lo));
    idle_inputs();
  endtask

  // Issues one instruction, measures the stall, and checks HI/LO.
  task automatic run_op(input string tag, input logic [5:0] code,
                        input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] exp;
    int          exp_stall;
    int          cycles;
    bit          long_op;
    exp       = ref_hilo(code, rs, rt, m_hi, m_lo);
    exp_stall = ref_stall(code, rt);
    long_op   = (exp_stall != 0);
    @(negedge clk);
    ex_valid   = 1'b1;
    ex_inscode = code;
    ex_rs_val  = rs;
    ex_rt_val  = rt;
    #1;
    cycles = 0;
    while (stall_req && cycles < 100) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall"}, 64'(cycles), 64'(exp_stall));
    if (long_op) check({tag, " done hilo"}, {hi_o, lo_o}, exp);
    @(negedge clk);
    idle_inputs();
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    #1;
    check({tag, " hilo"}, {hi_o, lo_o}, exp);
    check_mf(tag);
  endtask

  task automatic rand_op(input int idx);
    logic [5:0]  code;
    logic [31:0] rs, rt;
    case ($urandom_range(0, 5))
      0: code = IC_DIV;
      1: code = IC_DIVU;
      2: code = IC_MULT;
      3: code = IC_MULTU;
      4: code = IC_MTHI;
      default: code = IC_MTLO;
    endcase
    case ($urandom_range(0, 4))
      0: rs = 32'h8000_0000;
      1: rs = 32'hFFFF_FFFF;
      default: rs = $urandom;
    endcase
    case ($urandom_range(0, 5))
      0: rt = 32'd0;
      1: rt = $urandom_range(1, 15);
      2: rt = 32'hFFFF_FFFF;
      default: rt = $urandom;
    endcase
    run_op($sformatf("rand%0d", idx), code, rs, rt);
  endtask

  initial begin
    int i;
    idle_inputs();
    m_hi = '0;
    m_lo = '0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset stall", 64'(stall_req), 64'(0));
    check("reset hilo", {hi_o, lo_o}, 64'(0));
    check("reset mf", 64'(mfhilo_data), 64'(0));
    rst = 1'b0;

    run_op("mult neg", IC_MULT, 32'hFFFF_FFFE, 32'd3);
    run_op("divu 100/7", IC_DIVU, 32'd100, 32'd7);
    run_op("div -7/2", IC_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div 5/0", IC_DIV, 32'd5, 32'd0);
    run_op("div -9/0", IC_DIV, 32'hFFFF_FFF7, 32'd0);
    run_op("div min/-1", IC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("multu max", IC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mthi", IC_MTHI, 32'h1234_5678, 32'd0);
    run_op("mtlo", IC_MTLO, 32'h9ABC_DEF0, 32'd0);

    // Flush a DIVU during its 10th busy cycle.
    @(negedge clk);
    ex_valid   = 1'b1;
    ex_inscode = IC_DIVU;
    ex_rs_val  = 32'd1000;
    ex_rt_val  = 32'd3;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
    end
    #1;
    check("flush busy", 64'(stall_req), 64'(1));
    ex_flush = 1'b1;
    #1;
    check("flush stall", 64'(stall_req), 64'(0));
    @(negedge clk);
    idle_inputs();
    #1;
    check("post flush stall", 64'(stall_req), 64'(0));
    check("post flush hilo", {hi_o, lo_o}, {m_hi, m_lo});
    run_op("after flush", IC_MTLO, 32'h0BAD_F00D, 32'd0);

    // Asynchronous reset in the middle of a MULT.
    run_op("pre rst hi", IC_MTHI, 32'hAAAA_5555, 32'd0);
    @(negedge clk);
    ex_valid   = 1'b1;
    ex_inscode = IC_MULT;
    ex_rs_val  = 32'd7;
    ex_rt_val  = 32'd9;
    @(negedge clk);
    #2;
    check("mid mult stall", 64'(stall_req), 64'(1));
    rst = 1'b1;
    #1;
    check("rst mid stall", 64'(stall_req), 64'(0));
    check("rst mid hilo", {hi_o, lo_o}, 64'(0));
    idle_inputs();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;

    for (i = 0; i < 25; i++) rand_op(i);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
